// File: rtl/int_arbiter_if.sv
// Bus and core-handshake bundle for the interrupt arbiter.
// The arbiter takes the slave side; the bus fabric / core model takes the master side.
interface int_arbiter_if;
    logic        ic_we;
    logic [31:0] ic_adr;
    logic [31:0] ic_wdata;
    logic [31:0] ic_rdata;
    logic        int_ack_i;
    logic        int_req_o;
    logic [4:0]  int_id_o;

    modport slave (
        input  ic_we, ic_adr, ic_wdata, int_ack_i,
        output ic_rdata, int_req_o, int_id_o
    );

    modport master (
        output ic_we, ic_adr, ic_wdata, int_ack_i,
        input  ic_rdata, int_req_o, int_id_o
    );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches source pulses into pending bits, masks them with
// an enable register, picks one winner (fixed or round-robin priority) and runs
// a request / acknowledge / complete handshake so one interrupt is in service.
module int_arbiter #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    int_arbiter_if.slave       bus
);

    localparam logic [5:0] NUM_SRC_W = 6'(NUM_SRC);
    localparam logic [4:0] LAST_ID   = 5'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [NUM_SRC-1:0]   cand, id_mask, sw_clr, ack_clr;
    logic [4:0]           id_q, id_d;
    logic [4:0]           rr_ptr_q, rr_ptr_d;
    logic                 req_q;
    logic [4:0]           scan_start, win_ofs, win_id;
    logic [5:0]           win_sum;
    logic                 win_valid;
    logic [2*NUM_SRC-1:0] cand_dbl;
    logic [NUM_SRC-1:0]   cand_rot;
    logic                 wr_pending, wr_enable, wr_claim;
    logic                 unused_bus;

    assign wr_pending = bus.ic_we && (bus.ic_adr[3:0] == 4'h0);
    assign wr_enable  = bus.ic_we && (bus.ic_adr[3:0] == 4'h4);
    assign wr_claim   = bus.ic_we && (bus.ic_adr[3:0] == 4'h8);
    assign cand       = pending_q & enable_q;
    assign unused_bus = ^{bus.ic_adr[31:4], bus.ic_wdata};

    // One-hot mask of the latched id, used for withdrawal test and ack clear.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        id_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_mask[i] = (id_q == 5'(i));
        end
    end

    // Winner search: rotate candidates so the scan start sits at bit 0, take the lowest set bit.
    always_comb begin
        scan_start = (ARB_MODE != 0) ? rr_ptr_q : 5'd0;
        cand_dbl   = {cand, cand} >> scan_start;
        cand_rot   = cand_dbl[NUM_SRC-1:0];
        win_valid  = |cand_rot;
        win_ofs    = 5'd0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (cand_rot[j]) win_ofs = 5'(j);
        end
        win_sum = {1'b0, scan_start} + {1'b0, win_ofs};
        win_id  = (win_sum >= NUM_SRC_W) ? 5'(win_sum - NUM_SRC_W) : win_sum[4:0];
    end

    // Handshake state machine: next state, latched id, round-robin pointer, ack clear.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    id_d    = win_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack has priority over a withdrawal seen in the same cycle.
                if (bus.int_ack_i) begin
                    ack_clr = id_mask;
                    state_d = SERVICE;
                end else if (!(|(cand & id_mask))) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_claim && (bus.ic_wdata[4:0] == id_q)) begin
                    state_d = IDLE;
                    if (ARB_MODE != 0) begin
                        rr_ptr_d = (id_q == LAST_ID) ? 5'd0 : id_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending / enable next values; a new pulse beats any same-cycle clear.
    always_comb begin
        sw_clr    = wr_pending ? bus.ic_wdata[NUM_SRC-1:0] : '0;
        pending_d = (pending_q & ~sw_clr & ~ack_clr) | irq_src_i;
        enable_d  = wr_enable ? bus.ic_wdata[NUM_SRC-1:0] : enable_q;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= 5'd0;
            rr_ptr_q <= 5'd0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= (state_d == REQ);
        end
    end

    // Software-visible pending and enable registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
        end
    end

    // Combinational read mux; forced to zero while reset is held.
    always_comb begin
        bus.ic_rdata = 32'd0;
        if (rst_n) begin
            case (bus.ic_adr[3:0])
                4'h0:    bus.ic_rdata[NUM_SRC-1:0] = pending_q;
                4'h4:    bus.ic_rdata[NUM_SRC-1:0] = enable_q;
                4'h8:    bus.ic_rdata = {(state_q == SERVICE), 26'd0, id_q};
                4'hC:    bus.ic_rdata = {30'd0, state_q};
                default: bus.ic_rdata = 32'd0;
            endcase
        end
    end

    assign bus.int_req_o = req_q;
    assign bus.int_id_o  = id_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: a register-access vector table plus
// hand-written handshake sequences on a fixed-priority and a round-robin instance.
module tb_int_arbiter;

    localparam logic [31:0] A_PEND  = 32'h0;
    localparam logic [31:0] A_EN    = 32'h4;
    localparam logic [31:0] A_CLAIM = 32'h8;
    localparam logic [31:0] A_STAT  = 32'hC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_f, irq_r;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    int_arbiter_if bus_f ();
    int_arbiter_if bus_r ();

    int_arbiter #(.NUM_SRC(4), .ARB_MODE(0)) u_fix (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src_i (irq_f),
        .bus       (bus_f.slave)
    );

    int_arbiter #(.NUM_SRC(4), .ARB_MODE(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src_i (irq_r),
        .bus       (bus_r.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            bus_f.ic_we = 1'b1; bus_f.ic_adr = a; bus_f.ic_wdata = d;
        end else begin
            bus_r.ic_we = 1'b1; bus_r.ic_adr = a; bus_r.ic_wdata = d;
        end
        tick();
        bus_f.ic_we = 1'b0;
        bus_r.ic_we = 1'b0;
    endtask

    task automatic rd(input int s, input logic [31:0] a, output logic [31:0] d);
        if (s == 0) begin
            bus_f.ic_we = 1'b0; bus_f.ic_adr = a;
        end else begin
            bus_r.ic_we = 1'b0; bus_r.ic_adr = a;
        end
        #1;
        d = (s == 0) ? bus_f.ic_rdata : bus_r.ic_rdata;
    endtask

    task automatic rd_check(input int s, input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(s, a, v);
        check(name, v, exp);
    endtask

    task automatic pulse(input int s, input logic [3:0] m);
        if (s == 0) irq_f = m; else irq_r = m;
        tick();
        irq_f = 4'h0;
        irq_r = 4'h0;
    endtask

    task automatic ack(input int s);
        if (s == 0) bus_f.int_ack_i = 1'b1; else bus_r.int_ack_i = 1'b1;
        tick();
        bus_f.int_ack_i = 1'b0;
        bus_r.int_ack_i = 1'b0;
    endtask

    task automatic check_req(input int s, input string name, input logic req, input logic [4:0] id);
        if (s == 0) begin
            check({name, "_req"}, 32'(bus_f.int_req_o), 32'(req));
            check({name, "_id"},  32'(bus_f.int_id_o),  32'(id));
        end else begin
            check({name, "_req"}, 32'(bus_r.int_req_o), 32'(req));
            check({name, "_id"},  32'(bus_r.int_id_o),  32'(id));
        end
    endtask

    initial begin
        // Register access vectors right after reset (fixed-priority instance).
        vecs[0]  = '{1'b0, A_PEND,        32'h0,         32'h0};
        vecs[1]  = '{1'b0, A_EN,          32'h0,         32'h0};
        vecs[2]  = '{1'b0, A_CLAIM,       32'h0,         32'h0};
        vecs[3]  = '{1'b0, A_STAT,        32'h0,         32'h0};
        vecs[4]  = '{1'b1, A_EN,          32'hFFFF_FFF5, 32'h0};
        vecs[5]  = '{1'b0, A_EN,          32'h0,         32'h5};
        vecs[6]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h5};
        vecs[7]  = '{1'b0, 32'h0000_0002, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0002, 32'hFF,        32'h0};
        vecs[9]  = '{1'b0, A_EN,          32'h0,         32'h5};
        vecs[10] = '{1'b1, A_STAT,        32'h3,         32'h0};
        vecs[11] = '{1'b0, A_STAT,        32'h0,         32'h0};
        vecs[12] = '{1'b1, A_EN,          32'h0,         32'h0};

        rst_n = 1'b0;
        irq_f = 4'h0;
        irq_r = 4'h0;
        bus_f.ic_we = 1'b0; bus_f.ic_adr = 32'h0; bus_f.ic_wdata = 32'h0; bus_f.int_ack_i = 1'b0;
        bus_r.ic_we = 1'b0; bus_r.ic_adr = 32'h0; bus_r.ic_wdata = 32'h0; bus_r.int_ack_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check_req(0, "rst", 1'b0, 5'd0);
        check_req(1, "rst_rr", 1'b0, 5'd0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) wr(0, vecs[i].adr, vecs[i].data);
            else rd_check(0, $sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
        end
        rd_check(0, "vec_en_cleared", A_EN, 32'h0);

        // Single source: pulse -> pending -> request -> ack -> complete.
        wr(0, A_EN, 32'h1);
        pulse(0, 4'h1);
        rd_check(0, "b_pend_set", A_PEND, 32'h1);
        check_req(0, "b_n1", 1'b0, 5'd0);
        tick();
        check_req(0, "b_n2", 1'b1, 5'd0);
        ack(0);
        rd_check(0, "b_pend_ack", A_PEND, 32'h0);
        rd_check(0, "b_stat_svc", A_STAT, 32'h2);
        rd_check(0, "b_claim", A_CLAIM, 32'h8000_0000);
        check_req(0, "b_svc", 1'b0, 5'd0);
        wr(0, A_CLAIM, 32'h0);
        rd_check(0, "b_stat_idle", A_STAT, 32'h0);

        // Fixed priority: sources 1 and 3 together, 1 first.
        wr(0, A_EN, 32'hF);
        pulse(0, 4'hA);
        tick();
        check_req(0, "c_first", 1'b1, 5'd1);
        ack(0);
        check_req(0, "c_svc1", 1'b0, 5'd1);
        rd_check(0, "c_pend", A_PEND, 32'h8);
        wr(0, A_CLAIM, 32'h1);
        check_req(0, "c_k1", 1'b0, 5'd1);
        tick();
        check_req(0, "c_second", 1'b1, 5'd3);
        ack(0);
        wr(0, A_CLAIM, 32'h3);
        rd_check(0, "c_done", A_STAT, 32'h0);

        // Withdrawal by disabling the requested source.
        wr(0, A_EN, 32'h4);
        pulse(0, 4'h4);
        tick();
        check_req(0, "d_req", 1'b1, 5'd2);
        wr(0, A_EN, 32'h0);
        tick();
        check(  "d_req_drop", 32'(bus_f.int_req_o), 32'h0);
        rd_check(0, "d_stat", A_STAT, 32'h0);
        rd_check(0, "d_pend", A_PEND, 32'h4);
        wr(0, A_PEND, 32'h4);
        rd_check(0, "d_pend_clr", A_PEND, 32'h0);

        // Same-cycle ack and software clear of the latched source: ack wins.
        wr(0, A_EN, 32'h2);
        pulse(0, 4'h2);
        tick();
        check_req(0, "g_req", 1'b1, 5'd1);
        bus_f.int_ack_i = 1'b1;
        wr(0, A_PEND, 32'h2);
        bus_f.int_ack_i = 1'b0;
        rd_check(0, "g_stat", A_STAT, 32'h2);
        rd_check(0, "g_pend", A_PEND, 32'h0);
        wr(0, A_CLAIM, 32'h1);
        rd_check(0, "g_done", A_STAT, 32'h0);

        // Ack outside REQ is ignored.
        ack(0);
        rd_check(0, "h_stat", A_STAT, 32'h0);
        check(  "h_req", 32'(bus_f.int_req_o), 32'h0);

        // Round robin: complete id 1 (pointer -> 2), then 1 and 3 pending -> 3 wins, then wrap to 1.
        wr(1, A_EN, 32'hF);
        pulse(1, 4'h2);
        tick();
        check_req(1, "rr_a", 1'b1, 5'd1);
        ack(1);
        wr(1, A_CLAIM, 32'h1);
        pulse(1, 4'hA);
        tick();
        check_req(1, "rr_b", 1'b1, 5'd3);
        ack(1);
        wr(1, A_CLAIM, 32'h3);
        tick();
        check_req(1, "rr_wrap", 1'b1, 5'd1);

        // Wrong-id claim is ignored; pulses accumulate during service.
        wr(0, A_EN, 32'h1);
        pulse(0, 4'h1);
        tick();
        ack(0);
        wr(0, A_CLAIM, 32'h1);
        rd_check(0, "e_stay", A_STAT, 32'h2);
        pulse(0, 4'h1);
        rd_check(0, "e_pend", A_PEND, 32'h1);
        wr(0, A_CLAIM, 32'h0);
        rd_check(0, "e_idle", A_STAT, 32'h0);
        check(  "e_k1_req", 32'(bus_f.int_req_o), 32'h0);
        tick();
        check_req(0, "e_rereq", 1'b1, 5'd0);
        rd_check(0, "e_stat_req", A_STAT, 32'h1);

        // Same-cycle pulse and software clear of bit 2: pulse wins.
        irq_f = 4'h4;
        wr(0, A_PEND, 32'h4);
        irq_f = 4'h0;
        rd_check(0, "f_set_wins", A_PEND, 32'h5);
        ack(0);
        rd_check(0, "f_svc", A_STAT, 32'h2);

        // Reset from SERVICE: read data gated during reset, all state cleared.
        rst_n = 1'b0;
        rd_check(0, "r_rdata_gated", A_CLAIM, 32'h0);
        tick();
        check_req(0, "r_fix", 1'b0, 5'd0);
        check_req(1, "r_rr", 1'b0, 5'd0);
        rst_n = 1'b1;
        rd_check(0, "r_pend", A_PEND, 32'h0);
        rd_check(0, "r_en", A_EN, 32'h0);
        rd_check(0, "r_claim", A_CLAIM, 32'h0);
        rd_check(0, "r_stat", A_STAT, 32'h0);
        rd_check(1, "r_rr_en", A_EN, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
